mem_agu: RTL
============

MEM_AGU -- requirements
Module: mem_agu

Interface
REQ-001 Parameter WIDTH, default 64, sets the operand and result width in bits (legal values 8..64).
REQ-002 Parameter SCALE_MAX, default 3, sets the largest left-shift applied to operand2 (0..3).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  the upstream request is valid.
REQ-006 in_ready  output  1  the block accepts a request this cycle.
REQ-007 operand1  input  WIDTH  base value.
REQ-008 operand2  input  WIDTH  offset or immediate value.
REQ-009 op  input  2  00 add, 01 add-immediate, 10 sub, 11 sub-immediate.
REQ-010 scale  input  2  operand2 shift amount; values above SCALE_MAX saturate to SCALE_MAX.
REQ-011 size  input  2  log2 of the access bytes (0=1, 1=2, 2=4, 3=8).
REQ-012 out_valid  output  1  res, carry and misalign are valid.
REQ-013 out_ready  input  1  downstream takes the result.
REQ-014 res  output  WIDTH  computed address or value.
REQ-015 carry  output  1  carry-out on add ops; borrow on sub ops.
REQ-016 misalign  output  1  res is not aligned to 2^size bytes.

Function
REQ-017 The block SHALL accept a request on a clk edge where in_valid and in_ready are both 1.
REQ-018 The pipeline SHALL have two register stages: S1 captures operand1, operand2 shifted left by the effective scale (truncated to WIDTH), op and size; S2 captures res, carry and misalign.
REQ-019 Latency from acceptance to out_valid SHALL be exactly 2 cycles when out_ready is held at 1.
REQ-020 Throughput SHALL be one result per cycle with no bubbles while out_ready is 1.
REQ-021 Ops 00 and 01 SHALL compute res = (operand1 + shifted operand2) mod 2^WIDTH, with carry = bit WIDTH of the sum.
REQ-022 Ops 10 and 11 SHALL compute res = (operand1 - shifted operand2) mod 2^WIDTH, with carry = 1 exactly when operand1 < shifted operand2 (unsigned).
REQ-023 S2 SHALL advance when it is empty or out_ready is 1; S1 SHALL advance when it is empty or S2 advances.
REQ-024 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; it SHALL be driven combinationally, with no dependency on in_valid.
REQ-025 While out_valid is 1 and out_ready is 0, res, carry and misalign SHALL hold stable, and no accepted request SHALL be lost or duplicated.
REQ-026 With both stages full and out_ready at 0, in_ready SHALL be 0.
REQ-027 Simultaneous accept at S1 and drain at S2 in the same cycle SHALL keep occupancy unchanged.

Reset
REQ-028 While rst is 1, S1 valid, out_valid, res, carry and misalign SHALL be 0, asynchronously.
REQ-029 Reset mid-operation SHALL discard all in-flight requests; the first request after reset SHALL appear 2 cycles after its acceptance.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 When macro MEM_AGU_ALIGN_CHECK_EN is defined, misalign SHALL be 1 when any of res bits [size-1:0] is 1; misalign SHALL be 0 when size = 0.
REQ-032 When MEM_AGU_ALIGN_CHECK_EN is undefined, misalign SHALL be constant 0, size SHALL be ignored, and size SHALL not be stored.

Verification
REQ-033 Add: WIDTH=64, op=00, operand1=0x1000, operand2=0x10, scale=2, out_ready=1 -> res=0x1040, carry=0, out_valid exactly 2 cycles after accept.
REQ-034 Sub borrow: op=10, operand1=0x0, operand2=0x1, scale=0 -> res=0xFFFF_FFFF_FFFF_FFFF, carry=1.
REQ-035 Backpressure: 4 back-to-back requests, out_ready=0 for 5 cycles then 1 -> in_ready drops after 2 accepts; all 4 results emerge in order, each stable while stalled.
REQ-036 Alignment with MEM_AGU_ALIGN_CHECK_EN defined: op=00, operand1=0x1002, operand2=0, size=2 -> misalign=1; the same with size=1 -> misalign=0.
REQ-037 Reset mid-flight: assert rst with 2 requests in flight -> out_valid=0 immediately; after release, no stale result appears.
REQ-038 Scale saturation: SCALE_MAX=1, scale=3, operand2=0x4, operand1=0 -> res=0x8.

Source files
------------

// File: rtl/mem_agu.sv
// Two-stage address generation unit: scaled add/sub of base and offset with valid/ready flow control.
// Optional alignment check enabled by defining MEM_AGU_ALIGN_CHECK_EN.
module mem_agu #(
    parameter int WIDTH     = 64,
    parameter int SCALE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [1:0]       op,
    input  logic [1:0]       scale,
    input  logic [1:0]       size,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             misalign
);

    function automatic logic [1:0] sat_scale(input logic [1:0] s);
        if (int'(s) > SCALE_MAX)
            return 2'(SCALE_MAX);
        return s;
    endfunction

`ifdef MEM_AGU_ALIGN_CHECK_EN
    function automatic logic misalign_of(input logic [WIDTH-1:0] r, input logic [1:0] sz);
        case (sz)
            2'd1:    return r[0];
            2'd2:    return |r[1:0];
            2'd3:    return |r[2:0];
            default: return 1'b0;
        endcase
    endfunction
`endif

    logic             vld_p1, vld_p2;
    logic [WIDTH-1:0] op1_p1, op2_p1;
    logic             sub_p1;
    logic [WIDTH-1:0] res_p2;
    logic             carry_p2;
    logic             adv_p1, adv_p2, accept_p0;
    logic [WIDTH-1:0] op2_sh_p0;
    logic [WIDTH:0]   sum_p1;

    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1;
    assign accept_p0 = in_valid && adv_p1;

    // p0 -> p1: scale the offset; only op[1] distinguishes add from sub
    assign op2_sh_p0 = operand2 << sat_scale(scale);

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            op1_p1 <= operand1;
            op2_p1 <= op2_sh_p0;
            sub_p1 <= op[1];
        end
    end

    // p1 -> p2: the extra top bit of the widened result is carry on add and borrow on sub
    assign sum_p1 = sub_p1 ? ({1'b0, op1_p1} - {1'b0, op2_p1})
                           : ({1'b0, op1_p1} + {1'b0, op2_p1});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            res_p2   <= '0;
            carry_p2 <= 1'b0;
        end else begin
            if (adv_p1)
                vld_p1 <= in_valid;
            if (adv_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    res_p2   <= sum_p1[WIDTH-1:0];
                    carry_p2 <= sum_p1[WIDTH];
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign res       = res_p2;
    assign carry     = carry_p2;

`ifdef MEM_AGU_ALIGN_CHECK_EN
    logic [1:0] size_p1;
    logic       mis_p2;
    logic       unused_in;

    always_ff @(posedge clk) begin
        if (accept_p0)
            size_p1 <= size;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mis_p2 <= 1'b0;
        else if (adv_p2 && vld_p1)
            mis_p2 <= misalign_of(sum_p1[WIDTH-1:0], size_p1);
    end

    assign misalign  = mis_p2;
    assign unused_in = op[0];
`else
    logic unused_in;

    assign misalign  = 1'b0;
    assign unused_in = ^{op[0], size};
`endif

endmodule
